pdm_multi: RTL

PDM_MULTI -- requirements
Module: pdm_multi

---
 rtl/pdm_multi_pkg.sv | 19 +
 rtl/pdm_channel.sv | 67 ++++++
 rtl/pdm_multi.sv | 78 +++++++
 3 files changed

// File: rtl/pdm_multi_pkg.sv
// Shared definitions for the multi-channel PDM/PWM modulator: mode encoding
// and the write-channel index width.
`timescale 1ns/1ps
package pdm_multi_pkg;

    typedef enum logic {
        MODE_PDM = 1'b0,
        MODE_PWM = 1'b1
    } mode_e;

    function automatic int chan_idx_w(input int channels);
        if (channels > 1) begin
            return $clog2(channels);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pdm_channel.sv
// One modulator channel: host-written shadow level, frame-committed active
// level, sigma-delta accumulator and registered output bit.
`timescale 1ns/1ps
module pdm_channel
    import pdm_multi_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             commit,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] cnt,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             pdm_out
);

    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] acc_r;
    logic             out_r;
    logic [WIDTH:0]   sum_s;

    // Accumulator sum with carry-out in the top bit
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, active_r};
    end

    // Level registers, accumulator and output flop; the commit reads the
    // shadow before any same-cycle write lands, and the frame's last carry
    // is still emitted while the accumulator restarts at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r <= {WIDTH{1'b0}};
            active_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            out_r    <= 1'b0;
        end else begin
            if (wr) begin
                shadow_r <= wr_data;
            end else begin
                shadow_r <= shadow_r;
            end
            if (commit) begin
                active_r <= shadow_r;
            end else begin
                active_r <= active_r;
            end
            if (enable) begin
                acc_r <= commit ? {WIDTH{1'b0}} : sum_s[WIDTH-1:0];
                case (mode)
                    MODE_PWM: out_r <= (cnt < active_r);
                    MODE_PDM: out_r <= sum_s[WIDTH];
                    default:  out_r <= 1'b0;
                endcase
            end else begin
                acc_r <= acc_r;
                out_r <= 1'b0;
            end
        end
    end

    assign pdm_out = out_r;

endmodule

// File: rtl/pdm_multi.sv
// Multi-channel PDM/PWM modulator top: shared frame counter, commit and
// mode latch, write decode, and one pdm_channel per output bit.
`timescale 1ns/1ps
module pdm_multi
    import pdm_multi_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              mode,
    input  logic                              write_en,
    input  logic [chan_idx_w(CHANNELS)-1:0]   wr_chan,
    input  logic [WIDTH-1:0]                  wr_data,
    output logic [CHANNELS-1:0]               pdm_out,
    output logic                              frame_strobe
);

    localparam int               IDX_W   = chan_idx_w(CHANNELS);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;
    logic             commit_s;
    mode_e            mode_r;
    logic             strobe_r;

    // Commit happens on the last enabled cycle of each frame
    always_comb begin
        commit_s = enable && (cnt_r == CNT_MAX);
    end

    // Frame counter, frame-boundary mode latch and strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= {WIDTH{1'b0}};
            mode_r   <= MODE_PDM;
            strobe_r <= 1'b0;
        end else begin
            if (enable) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (commit_s) begin
                mode_r <= mode_e'(mode);
            end else begin
                mode_r <= mode_r;
            end
            strobe_r <= commit_s;
        end
    end

    assign frame_strobe = strobe_r;

    // Out-of-range channel indices match no instance and are dropped
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic wr_s;
        assign wr_s = write_en && (wr_chan == IDX_W'(c));

        pdm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (enable),
            .commit  (commit_s),
            .mode    (mode_r),
            .cnt     (cnt_r),
            .wr      (wr_s),
            .wr_data (wr_data),
            .pdm_out (pdm_out[c])
        );
    end

endmodule
